// File: rtl/sigma_delta_adc_scheduler_pkg.sv
// Shared types and constants for the sigma-delta ADC scheduler.
package sigma_delta_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int unsigned OVR_W = 8;

endpackage

// File: rtl/sigma_delta_adc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter
  import sigma_delta_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] id
);

  logic            w_found;
  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;

  // Walk the requesters starting at ptr, wrapping modulo NREQ.
  always_comb begin
    gnt     = '0;
    id      = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (w_sum >= (ID_W+1)'(NREQ)) w_sum = w_sum - (ID_W+1)'(NREQ);
      w_idx = w_sum[ID_W-1:0];
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        id         = w_idx;
      end
    end
  end

endmodule

// File: rtl/sigma_delta_adc_scheduler.sv
// Shares one sigma-delta ADC core between NREQ burst requesters.
module sigma_delta_adc_scheduler
  import sigma_delta_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WDTH   = 16,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    adc_rst,
  input  logic [WDTH-1:0]         adc_data,
  input  logic                    adc_valid,
  output logic [WDTH-1:0]         smp_data,
  output logic [$clog2(NREQ)-1:0] smp_id,
  output logic                    smp_valid,
  input  logic                    smp_ready,
  output logic [OVR_W-1:0]        ovr_cnt,
  output logic                    busy
);

  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned SET_W = $clog2(SETTLE + 2);

  state_t           r_state, w_state_nxt;
  logic [NREQ-1:0]  r_gnt;
  logic [ID_W-1:0]  r_id, r_ptr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W:0]   r_cnt;
  logic [SET_W-1:0] r_settle;
  logic             r_adc_rst;
  logic [WDTH-1:0]  r_smp_data;
  logic [ID_W-1:0]  r_smp_id;
  logic             r_smp_valid;
  logic [OVR_W-1:0] r_ovr;

  logic [LEN_W-1:0] w_len_arr [NREQ];
  logic [NREQ-1:0]  w_id_onehot, w_arb_req, w_arb_gnt;
  logic [ID_W-1:0]  w_ptr_inc, w_arb_ptr, w_arb_id;
  logic             w_room, w_run_ok, w_load, w_drop, w_last;
  logic             w_take, w_fin_exit;

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign w_len_arr[g] = req_len[g*LEN_W +: LEN_W];
  end

  assign w_id_onehot = NREQ'(1) << r_id;
  assign w_ptr_inc   = (r_id == ID_W'(NREQ - 1)) ? '0 : r_id + 1'b1;

  // FIN re-arbitrates before ptr is registered and while the finishing
  // requester still holds req, so use the post-burst ptr and mask that id.
  assign w_arb_ptr = (r_state == FIN) ? w_ptr_inc : r_ptr;
  assign w_arb_req = (r_state == FIN) ? (req & ~w_id_onehot) : req;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req (w_arb_req),
    .ptr (w_arb_ptr),
    .gnt (w_arb_gnt),
    .id  (w_arb_id)
  );

  assign w_room   = !r_smp_valid || smp_ready;
  assign w_run_ok = (r_state == RUN) && req[r_id];
  assign w_load   = w_run_ok && adc_valid && w_room;
  assign w_drop   = w_run_ok && adc_valid && !w_room;
  assign w_last   = (r_cnt == {1'b0, r_len});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode plus grant/exit strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_fin_exit  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_take      = 1'b1;
          w_state_nxt = (SETTLE == 0) ? RUN : WARM;
        end
      end
      WARM: begin
        if (!req[r_id])                                          w_state_nxt = FIN;
        else if (adc_valid && (r_settle == SET_W'(SETTLE - 1))) w_state_nxt = RUN;
      end
      RUN: begin
        if (!req[r_id])           w_state_nxt = FIN;
        else if (w_load && w_last) w_state_nxt = FIN;
      end
      FIN: begin
        if (!r_smp_valid) begin
          w_fin_exit = 1'b1;
          if (|w_arb_req) begin
            w_take      = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping, counters, output register and overrun counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= '0;
      r_id        <= '0;
      r_ptr       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_settle    <= '0;
      r_adc_rst   <= 1'b1;
      r_smp_data  <= '0;
      r_smp_id    <= '0;
      r_smp_valid <= 1'b0;
      r_ovr       <= '0;
    end else begin
      r_adc_rst <= (w_state_nxt == IDLE);
      if (w_take) begin
        r_gnt    <= w_arb_gnt;
        r_id     <= w_arb_id;
        r_len    <= w_len_arr[w_arb_id];
        r_cnt    <= '0;
        r_settle <= '0;
      end else if (w_fin_exit) begin
        r_gnt <= '0;
      end
      if (w_fin_exit) r_ptr <= w_ptr_inc;
      if (r_state == WARM && adc_valid) r_settle <= r_settle + 1'b1;
      if (w_load) begin
        r_cnt       <= r_cnt + 1'b1;
        r_smp_data  <= adc_data;
        r_smp_id    <= r_id;
        r_smp_valid <= 1'b1;
      end else if (r_smp_valid && smp_ready) begin
        r_smp_valid <= 1'b0;
      end
      if (w_drop && (r_ovr != '1)) r_ovr <= r_ovr + 1'b1;
    end
  end

  assign gnt       = r_gnt;
  assign done      = w_fin_exit ? w_id_onehot : '0;
  assign adc_rst   = r_adc_rst;
  assign smp_data  = r_smp_data;
  assign smp_id    = r_smp_id;
  assign smp_valid = r_smp_valid;
  assign ovr_cnt   = r_ovr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sigma_delta_adc_scheduler.sv
// Directed bench for sigma_delta_adc_scheduler with a sample scoreboard.
module tb_sigma_delta_adc_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_len = '0;
  logic [15:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        smp_ready = 1'b0;
  logic [3:0]  gnt, done;
  logic        adc_rst;
  logic [15:0] smp_data;
  logic [1:0]  smp_id;
  logic        smp_valid;
  logic [7:0]  ovr_cnt;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        auto_drop = 1'b0;
  int          done_cnt [4];
  int          hs_cnt = 0;
  logic [3:0]  gnt_log [$];
  logic [3:0]  prev_gnt = '0;
  logic [17:0] exp_q [$];
  int          exp_rd = 0;

  sigma_delta_adc_scheduler #(.NREQ(4), .WDTH(16), .LEN_W(8), .SETTLE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_len   (req_len),
    .gnt       (gnt),
    .done      (done),
    .adc_rst   (adc_rst),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .smp_data  (smp_data),
    .smp_id    (smp_id),
    .smp_valid (smp_valid),
    .smp_ready (smp_ready),
    .ovr_cnt   (ovr_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, then return #1 after the rising edge.
  task automatic tick();
    logic [17:0] e;
    @(negedge clk);
    if (smp_valid && smp_ready) begin
      hs_cnt++;
      if (exp_rd < exp_q.size()) begin
        e = exp_q[exp_rd];
        chk("sb_data", 32'(smp_data), 32'(e[15:0]));
        chk("sb_id", 32'(smp_id), 32'(e[17:16]));
        exp_rd++;
      end else begin
        chk("sb_unexpected", 32'(smp_valid & smp_ready), 32'd0);
      end
    end
    if (done[0]) done_cnt[0]++;
    if (done[1]) done_cnt[1]++;
    if (done[2]) done_cnt[2]++;
    if (done[3]) done_cnt[3]++;
    if (done != 4'd0) chk("done_onehot", 32'($countones(done)), 32'd1);
    if (gnt != prev_gnt && gnt != 4'd0) gnt_log.push_back(gnt);
    prev_gnt = gnt;
    if (auto_drop) req = req & ~done;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] d, input logic keep, input logic [1:0] id);
    adc_data  = d;
    adc_valid = 1'b1;
    if (keep) exp_q.push_back({id, d});
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic check_reset(input string p);
    chk({p, "_gnt"},     32'(gnt), 32'd0);
    chk({p, "_done"},    32'(done), 32'd0);
    chk({p, "_adc_rst"}, 32'(adc_rst), 32'd1);
    chk({p, "_valid"},   32'(smp_valid), 32'd0);
    chk({p, "_data"},    32'(smp_data), 32'd0);
    chk({p, "_id"},      32'(smp_id), 32'd0);
    chk({p, "_ovr"},     32'(ovr_cnt), 32'd0);
    chk({p, "_busy"},    32'(busy), 32'd0);
  endtask

  task automatic clear_stats();
    done_cnt[0] = 0; done_cnt[1] = 0; done_cnt[2] = 0; done_cnt[3] = 0;
    hs_cnt = 0;
    exp_q.delete();
    exp_rd = 0;
    gnt_log.delete();
  endtask

  task automatic do_reset(input string p);
    rst = 1'b1; req = '0; adc_valid = 1'b0; smp_ready = 1'b0; req_len = '0;
    tick(); tick();
    check_reset(p);
    rst = 1'b0;
    clear_stats();
  endtask

  initial begin
    logic [3:0] eg;
    int b;

    // Single burst: req[1], L=3, two settling strobes discarded.
    do_reset("rst0");
    req_len[15:8] = 8'd3; smp_ready = 1'b1; auto_drop = 1'b1; req = 4'b0010;
    tick();
    chk("t1_gnt", 32'(gnt), 32'h2);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_adc_rst", 32'(adc_rst), 32'd0);
    for (int k = 0; k < 10; k++) strobe(16'hA000 + 16'(k), (k >= 2 && k <= 5), 2'd1);
    tick(); tick();
    chk("t1_done1", 32'(done_cnt[1]), 32'd1);
    chk("t1_done_other", 32'(done_cnt[0] + done_cnt[2] + done_cnt[3]), 32'd0);
    chk("t1_adc_rst_end", 32'(adc_rst), 32'd1);
    chk("t1_ovr", 32'(ovr_cnt), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_hs", 32'(hs_cnt), 32'd4);
    chk("t1_drained", 32'(exp_rd), 32'(exp_q.size()));

    // Round-robin with all requests held, L=0: loads every third strobe after warm-up.
    do_reset("rst1");
    smp_ready = 1'b1; auto_drop = 1'b0; req = 4'b1111;
    tick();
    for (int k = 0; k < 16; k++) begin
      b = (k - 2) / 3;
      strobe(16'hB000 + 16'(k), (k >= 2 && ((k - 2) % 3) == 0), 2'(b % 4));
    end
    req = '0;
    tick(); tick(); tick();
    chk("t2_nlog", 32'(gnt_log.size()), 32'd5);
    eg = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      chk("t2_order", 32'((i < gnt_log.size()) ? gnt_log[i] : 4'h0), 32'(eg));
      eg = {eg[2:0], eg[3]};
    end
    chk("t2_hs", 32'(hs_cnt), 32'd5);
    chk("t2_ovr", 32'(ovr_cnt), 32'd0);
    chk("t2_done0", 32'(done_cnt[0]), 32'd2);
    chk("t2_done3", 32'(done_cnt[3]), 32'd1);
    chk("t2_drained", 32'(exp_rd), 32'(exp_q.size()));

    // Same-cycle handshake and load on every strobe.
    do_reset("rst2");
    req_len[7:0] = 8'd7; smp_ready = 1'b1; auto_drop = 1'b1; req = 4'b0001;
    tick();
    for (int k = 0; k < 10; k++) strobe(16'hC000 + 16'(k), (k >= 2), 2'd0);
    tick(); tick(); tick();
    chk("t3_ovr", 32'(ovr_cnt), 32'd0);
    chk("t3_hs", 32'(hs_cnt), 32'd8);
    chk("t3_done0", 32'(done_cnt[0]), 32'd1);
    chk("t3_drained", 32'(exp_rd), 32'(exp_q.size()));
    chk("t3_adc_rst", 32'(adc_rst), 32'd1);

    // Backpressure: held sample stable, drops counted and saturating.
    do_reset("rst3");
    req_len[7:0] = 8'd3; smp_ready = 1'b0; auto_drop = 1'b1; req = 4'b0001;
    tick();
    strobe(16'hD000, 1'b0, 2'd0);
    strobe(16'hD001, 1'b0, 2'd0);
    strobe(16'hD002, 1'b1, 2'd0);
    chk("t4_valid", 32'(smp_valid), 32'd1);
    chk("t4_data", 32'(smp_data), 32'hD002);
    chk("t4_ovr0", 32'(ovr_cnt), 32'd0);
    strobe(16'hD003, 1'b0, 2'd0);
    chk("t4_hold1", 32'(smp_data), 32'hD002);
    strobe(16'hD004, 1'b0, 2'd0);
    chk("t4_hold2", 32'(smp_data), 32'hD002);
    chk("t4_hold_id", 32'(smp_id), 32'd0);
    chk("t4_ovr2", 32'(ovr_cnt), 32'd2);
    for (int k = 0; k < 300; k++) strobe(16'h5000 + 16'(k), 1'b0, 2'd0);
    chk("t4_ovr_sat", 32'(ovr_cnt), 32'd255);
    chk("t4_hold3", 32'(smp_data), 32'hD002);
    chk("t4_valid3", 32'(smp_valid), 32'd1);
    smp_ready = 1'b1;
    strobe(16'hD010, 1'b1, 2'd0);
    strobe(16'hD011, 1'b1, 2'd0);
    strobe(16'hD012, 1'b1, 2'd0);
    tick(); tick(); tick();
    chk("t4_ovr_end", 32'(ovr_cnt), 32'd255);
    chk("t4_hs", 32'(hs_cnt), 32'd4);
    chk("t4_done0", 32'(done_cnt[0]), 32'd1);
    chk("t4_drained", 32'(exp_rd), 32'(exp_q.size()));

    // Abort: req[2] drops with one sample held; held sample still delivered.
    do_reset("rst4");
    req_len[23:16] = 8'd4; smp_ready = 1'b1; auto_drop = 1'b1; req = 4'b0100;
    tick();
    chk("t5_gnt", 32'(gnt), 32'h4);
    strobe(16'hF000, 1'b0, 2'd2);
    strobe(16'hF001, 1'b0, 2'd2);
    strobe(16'hF002, 1'b1, 2'd2);
    strobe(16'hF003, 1'b1, 2'd2);
    smp_ready = 1'b0; req = '0;
    tick();
    chk("t5_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) strobe(16'hF010 + 16'(k), 1'b0, 2'd2);
    chk("t5_held", 32'(smp_data), 32'hF003);
    chk("t5_ovr", 32'(ovr_cnt), 32'd0);
    smp_ready = 1'b1;
    tick(); tick(); tick();
    chk("t5_done2", 32'(done_cnt[2]), 32'd1);
    chk("t5_hs", 32'(hs_cnt), 32'd2);
    chk("t5_drained", 32'(exp_rd), 32'(exp_q.size()));
    chk("t5_busy_end", 32'(busy), 32'd0);

    // Reset mid-burst with a held sample, then a lone req[3].
    do_reset("rst5");
    req_len[15:8] = 8'd3; smp_ready = 1'b0; auto_drop = 1'b1; req = 4'b0010;
    tick();
    strobe(16'h7000, 1'b0, 2'd1);
    strobe(16'h7001, 1'b0, 2'd1);
    strobe(16'h7002, 1'b0, 2'd1);
    chk("t6_pre_valid", 32'(smp_valid), 32'd1);
    rst = 1'b1; req = '0;
    tick();
    check_reset("t6_rst");
    rst = 1'b0; req = 4'b1000;
    tick();
    chk("t6_gnt3", 32'(gnt), 32'h8);
    smp_ready = 1'b1;
    strobe(16'h7100, 1'b0, 2'd3);
    strobe(16'h7101, 1'b0, 2'd3);
    strobe(16'h7102, 1'b1, 2'd3);
    tick(); tick(); tick();
    chk("t6_done3", 32'(done_cnt[3]), 32'd1);
    chk("t6_done1", 32'(done_cnt[1]), 32'd0);
    chk("t6_drained", 32'(exp_rd), 32'(exp_q.size()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sigma_delta_adc_scheduler.md
# sigma_delta_adc_scheduler

Shares one sigma-delta ADC core between up to NREQ requesters. Each requester asks for a burst of samples; the scheduler grants requesters round-robin and holds the ADC core in power-save reset while idle. On wake-up it discards the CIC settling outputs, then delivers tagged samples through a valid/ready output register. It sits between the ADC core's adc_output/adc_valid and the consumers.

## Interface
- NREQ, 4, number of requesters (2..16)
- WDTH, 16, sample width, equal to ADC core WDTH
- LEN_W, 8, burst length field width
- SETTLE, 2, ADC valid outputs discarded after power-up (0 allowed)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester request level, held until its done pulse
- req_len  in  NREQ*LEN_W  burst length per requester, value L means L+1 samples; sampled at grant
- gnt  out  NREQ  one-hot grant, registered
- done  out  NREQ  one-hot one-cycle burst-complete pulse
- adc_rst  out  1  power-save reset to ADC core, registered
- adc_data  in  WDTH  ADC core sample
- adc_valid  in  1  ADC core sample strobe
- smp_data  out  WDTH  delivered sample
- smp_id  out  $clog2(NREQ)  owner of smp_data
- smp_valid  out  1  output register full
- smp_ready  in  1  consumer accepts when smp_valid&smp_ready
- ovr_cnt  out  8  saturating dropped-sample count
- busy  out  1  state != IDLE

## Operation
- States IDLE, WARM, RUN, FIN.
- IDLE: adc_rst=1, gnt=0. Any req bit → arbitrate, latch id and req_len[id], set gnt[id], go to WARM (or straight to RUN if SETTLE=0); adc_rst=0 from the next cycle.
- Arbitration: round-robin. Search starts at ptr, where ptr=(last granted id+1) mod NREQ; reset ptr=0.
- WARM: count adc_valid; the first SETTLE strobes are discarded (no load, no overrun); go to RUN on the SETTLE-th strobe.
- RUN: on adc_valid, if the register is empty or being consumed the same cycle → load adc_data with smp_id=id and increment the sample count. Otherwise drop the sample, ovr_cnt++ (saturates at 255).
- RUN exits to FIN when count reaches L+1 loaded samples, or when req[id] deasserts (abort). After an abort, no further loads occur, but the held sample is still delivered.
- FIN: wait for the output register to empty, then pulse done[id], clear gnt, update ptr, and arbitrate in the same cycle.
  - A pending req → new grant, go to RUN directly. The ADC stays powered, so WARM is skipped.
  - No pending req → IDLE, adc_rst=1 next cycle.
- Changes to req_len after grant are ignored. A req rising during a burst waits.
- Rst mid-operation: immediate return to reset values. The held sample is lost and no done pulse is issued.

## Timing
- Reset values: gnt=0, done=0, adc_rst=1, smp_valid=0, smp_data=0, smp_id=0, ovr_cnt=0, busy=0, ptr=0.
- Request to grant: req seen in IDLE at cycle n → gnt and busy at n+1, adc_rst low at n+1.
- Sample latency: adc_valid accepted at cycle n → smp_valid at n+1.
- Output register rules: smp_data and smp_id are stable while smp_valid&!smp_ready. smp_valid never drops without a handshake.
- Same-cycle consume and load: a handshake and adc_valid in the same cycle → the new sample loads with no bubble and no overrun.
- done timing: done pulses in the cycle after the last handshake. For back-to-back bursts, the new gnt is visible on the cycle following done.
- Abort in WARM: go to FIN with count 0; done pulses the next cycle.

## Structure
- Package sigma_delta_pkg holds a state enum type (IDLE, WARM, RUN, FIN) and an ovr_cnt width constant of 8.
- Sub-module rr_arbiter (NREQ): inputs req and ptr; outputs one-hot gnt and encoded id. It is combinational.
- The scheduler holds the FSM, counters, output register and ptr.

## Test plan
- Single burst, NREQ=4, SETTLE=2, req[1] with L=3, smp_ready=1, 10 ADC strobes → first 2 strobes dropped, next 4 delivered with smp_id=1, done[1] pulses once, then adc_rst=1 and ovr_cnt=0.
- Round-robin fairness: req=4'b1111 held, all L=0 → grants in order 0,1,2,3,0. The first burst passes through WARM, later bursts go straight to RUN with no discards.
- Backpressure: smp_ready=0 for 3 strobes in RUN → first sample held and stable, 2 dropped, ovr_cnt=2. Holding smp_ready=0 for 300 strobes → ovr_cnt saturates at 255.
- Same-cycle handshake and adc_valid on every strobe at 1-cycle spacing → no drops, ovr_cnt=0.
- Abort: req[2] drops after 2 of 5 samples, with one sample held → held sample delivered, done[2] pulses, no further loads.
- rst asserted in RUN with smp_valid=1 → next cycle all outputs at reset values, adc_rst=1, no done pulse. After reset, req[3] is granted first, since ptr=0 and 3 is the only requester.
